// File: rtl/sqvl_pkg.sv
// sqvl_pkg: shared types and defaults for the SQVL square-wave level source.
//   DW      level code width
//   CW      phase-length counter width
//   EN_DLY  cycles from a Dout update to its EN strobe (downstream pipeline depth)
//   sqvl_state_e  FSM states IDLE / HIGH / LOW
//   sqvl_cfg_t    levels, phase lengths and slew step, as held in shadow/active
package sqvl_pkg;

    localparam int DW     = 12;
    localparam int CW     = 16;
    localparam int EN_DLY = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } sqvl_state_e;

    typedef struct packed {
        logic [DW-1:0] hi_level;
        logic [DW-1:0] lo_level;
        logic [CW-1:0] hi_cycles;
        logic [CW-1:0] lo_cycles;
        logic [DW-1:0] slew_step;
    } sqvl_cfg_t;

    // A programmed length of 0 behaves as a one-cycle phase.
    function automatic logic [CW-1:0] eff_len(input logic [CW-1:0] n);
        return (n == '0) ? CW'(1) : n;
    endfunction

    // One slew step toward tgt, clamped so the target is never overshot.
    // Step 0 is a direct jump.
    function automatic logic [DW-1:0] slew_next(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] tgt,
                                                input logic [DW-1:0] step);
        logic [DW-1:0] diff;
        if (step == '0 || cur == tgt) return tgt;
        if (cur < tgt) begin
            diff = tgt - cur;
            return (diff <= step) ? tgt : cur + step;
        end
        diff = cur - tgt;
        return (diff <= step) ? tgt : cur - step;
    endfunction

endpackage

// File: rtl/sqvl_en_delay.sv
// sqvl_en_delay: DEPTH-stage shift register that delays the level-update
// marker so EN reaches the voltage path together with the Dout value that
// has travelled through its register pipeline.
//   Clock   in  rising-edge clock
//   nReset  in  asynchronous active-low clear (drops pulses in flight)
//   mark_i  in  update marker
//   en_o    out marker delayed by DEPTH cycles
module sqvl_en_delay
    import sqvl_pkg::*;
#(
    parameter int DEPTH = EN_DLY
) (
    input  logic Clock,
    input  logic nReset,
    input  logic mark_i,
    output logic en_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = mark_i;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) sr_q <= '0;
        else         sr_q <= sr_d;
    end

    assign en_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sqvl_level_gen.sv
// sqvl_level_gen: square-wave level source for the SQVL voltage path.
// Alternates Dout between the high and low level codes for programmed phase
// lengths and emits an EN strobe EN_DLY cycles after every Dout change.
// New settings go to a shadow copy and reach the active copy only at a
// period start (or immediately while idle), so a period is never glitched.
//
// Handshake: Load is accepted on a rising edge where Ready=1; the inputs are
// captured into shadow and Ready stays low until the commit edge. Load while
// Ready=0 is ignored.
//
// Optional feature macro: SQVL_SLEW_EN -- Dout ramps by SlewStep per cycle
// (each step strobes EN); otherwise Dout jumps and SlewStep is ignored.
//
// Ports:
//   Clock, nReset          clock, asynchronous active-low reset
//   Run                    1 = generate, 0 = park at low level (IDLE)
//   Load / Ready           shadow-load request / acceptance
//   HiLevel, LoLevel       level codes (DW)
//   HiCycles, LoCycles     phase lengths in clocks (CW), 0 behaves as 1
//   SlewStep               ramp step (DW), SQVL_SLEW_EN only
//   Dout, EN, Phase        level code, latch strobe, 1 = high phase
//   DbgState               current FSM state
module sqvl_level_gen
    import sqvl_pkg::*;
(
    input  logic          Clock,
    input  logic          nReset,
    input  logic          Run,
    input  logic          Load,
    output logic          Ready,
    input  logic [DW-1:0] HiLevel,
    input  logic [DW-1:0] LoLevel,
    input  logic [CW-1:0] HiCycles,
    input  logic [CW-1:0] LoCycles,
    input  logic [DW-1:0] SlewStep,
    output logic [DW-1:0] Dout,
    output logic          EN,
    output logic          Phase,
    output sqvl_state_e   DbgState
);

    sqvl_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    sqvl_cfg_t     act_q, act_d;
    sqvl_cfg_t     shd_q, shd_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          phase_q;
    logic          upd_q;
    logic          enter_high;
    logic          commit;
    logic          load_ok;
    logic [DW-1:0] target;

    // Next state and phase counter. Run=0 overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_high = 1'b0;
        if (!Run) begin
            state_d = ST_IDLE;
            cnt_d   = CW'(1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_HIGH;
                    cnt_d      = CW'(1);
                    enter_high = 1'b1;
                end
                ST_HIGH: begin
                    if (cnt_q >= eff_len(act_q.hi_cycles)) begin
                        state_d = ST_LOW;
                        cnt_d   = CW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt_q >= eff_len(act_q.lo_cycles)) begin
                        state_d    = ST_HIGH;
                        cnt_d      = CW'(1);
                        enter_high = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CW'(1);
                end
            endcase
        end
    end

    // Shadow capture and commit. A Load can only be accepted with pend_q=0,
    // and a commit needs pend_q=1, so a Load arriving at a period start is
    // committed at the following period start.
    always_comb begin
        load_ok = Load && !pend_q;
        commit  = pend_q && ((state_q == ST_IDLE) || enter_high);
        shd_d   = shd_q;
        act_d   = act_q;
        pend_d  = pend_q;
        if (load_ok) begin
            shd_d.hi_level  = HiLevel;
            shd_d.lo_level  = LoLevel;
            shd_d.hi_cycles = HiCycles;
            shd_d.lo_cycles = LoCycles;
            shd_d.slew_step = SlewStep;
            pend_d          = 1'b1;
        end
        if (commit) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
    end

    // Dout follows the registered state, so it (and Phase) trail the FSM by
    // one cycle: Run sampled at edge 0 shows HiLevel after edge 1.
    assign target = (state_q == ST_HIGH) ? act_q.hi_level : act_q.lo_level;

`ifdef SQVL_SLEW_EN
    assign dout_d = slew_next(dout_q, target, act_q.slew_step);
`else
    logic unused_slew;
    assign unused_slew = ^act_q.slew_step;
    assign dout_d      = target;
`endif

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CW'(1);
            act_q   <= '0;
            shd_q   <= '0;
            pend_q  <= 1'b0;
            dout_q  <= '0;
            phase_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            phase_q <= (state_q == ST_HIGH);
            upd_q   <= (dout_d != dout_q);
        end
    end

    sqvl_en_delay #(.DEPTH(EN_DLY)) u_en_delay (
        .Clock  (Clock),
        .nReset (nReset),
        .mark_i (upd_q),
        .en_o   (EN)
    );

    assign Dout     = dout_q;
    assign Phase    = phase_q;
    assign Ready    = !pend_q;
    assign DbgState = state_q;

endmodule

// File: tb/tb_sqvl_level_gen.sv
module tb_sqvl_level_gen;
    import sqvl_pkg::*;

    localparam int M_IDLE = 0;
    localparam int M_HIGH = 1;
    localparam int M_LOW  = 2;

    // ---------------- clock / reset ----------------
    logic          Clock = 1'b0;
    logic          nReset;
    logic          Run;
    logic          Load;
    logic          Ready;
    logic [DW-1:0] HiLevel;
    logic [DW-1:0] LoLevel;
    logic [CW-1:0] HiCycles;
    logic [CW-1:0] LoCycles;
    logic [DW-1:0] SlewStep;
    logic [DW-1:0] Dout;
    logic          EN;
    logic          Phase;
    sqvl_state_e   DbgState;

    always #5 Clock = ~Clock;

    sqvl_level_gen dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .Run      (Run),
        .Load     (Load),
        .Ready    (Ready),
        .HiLevel  (HiLevel),
        .LoLevel  (LoLevel),
        .HiCycles (HiCycles),
        .LoCycles (LoCycles),
        .SlewStep (SlewStep),
        .Dout     (Dout),
        .EN       (EN),
        .Phase    (Phase),
        .DbgState (DbgState)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural reference model ----------------
    // Mode, cycles left in the current phase, active/shadow settings, and a
    // history of update flags from which EN is read EN_DLY entries back.
    int m_mode, m_left, m_dout;
    int m_ahi, m_alo, m_ahc, m_alc, m_astep;
    int m_shi, m_slo, m_shc, m_slc, m_sstep;
    bit m_pend, m_phase, m_en;
    bit upd_hist[$];

    function automatic int len_of(int n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int next_level(int cur, int tgt, int step);
        int nxt;
        nxt = tgt;
`ifdef SQVL_SLEW_EN
        if (step != 0) begin
            if (cur < tgt)      nxt = (tgt - cur <= step) ? tgt : cur + step;
            else if (cur > tgt) nxt = (cur - tgt <= step) ? tgt : cur - step;
        end
`endif
        return nxt;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_dout = 0;
        m_ahi = 0; m_alo = 0; m_ahc = 0; m_alc = 0; m_astep = 0;
        m_shi = 0; m_slo = 0; m_shc = 0; m_slc = 0; m_sstep = 0;
        m_pend = 0; m_phase = 0; m_en = 0;
        upd_hist.delete();
    endtask

    task automatic model_step();
        int tgt, nd, nmode;
        bit upd, enter_hi, commit, load_ok;
        tgt = (m_mode == M_HIGH) ? m_ahi : m_alo;
        nd  = next_level(m_dout, tgt, m_astep);
        upd = (nd != m_dout);
        if (!Run)                 nmode = M_IDLE;
        else if (m_mode == M_IDLE) nmode = M_HIGH;
        else if (m_left <= 1)     nmode = (m_mode == M_HIGH) ? M_LOW : M_HIGH;
        else                      nmode = m_mode;
        enter_hi = (nmode == M_HIGH) && (m_mode != M_HIGH);
        commit   = m_pend && ((m_mode == M_IDLE) || enter_hi);
        load_ok  = Load && !m_pend;
        m_phase  = (m_mode == M_HIGH);
        m_dout   = nd;
        if (commit) begin
            m_ahi = m_shi; m_alo = m_slo; m_ahc = m_shc; m_alc = m_slc; m_astep = m_sstep;
            m_pend = 0;
        end
        if (load_ok) begin
            m_shi = int'(HiLevel); m_slo = int'(LoLevel);
            m_shc = int'(HiCycles); m_slc = int'(LoCycles); m_sstep = int'(SlewStep);
            m_pend = 1;
        end
        if (enter_hi)                                m_left = len_of(m_ahc);
        else if (nmode == M_LOW && m_mode != M_LOW)  m_left = len_of(m_alc);
        else                                         m_left = m_left - 1;
        m_mode = nmode;
        upd_hist.push_back(upd);
        m_en = (upd_hist.size() > EN_DLY) ? upd_hist[upd_hist.size() - 1 - EN_DLY] : 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge Clock);
        if (nReset) model_step();
        @(negedge Clock);
    endtask

    task automatic load_cfg(input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                            input int hc, input int lc, input logic [DW-1:0] step);
        HiLevel  = hi;
        LoLevel  = lo;
        HiCycles = CW'(hc);
        LoCycles = CW'(lc);
        SlewStep = step;
        Load     = 1'b1;
        cycle();
        Load     = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nReset = 1'b1; Run = 1'b0; Load = 1'b0;
        HiLevel = '0; LoLevel = '0; HiCycles = '0; LoCycles = '0; SlewStep = '0;
        #2 nReset = 1'b0;
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        n_tests++;
        if ({Dout, EN, Phase, Ready} !== {12'h000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%h en=%b ph=%b rdy=%b, exp dout=000 en=0 ph=0 rdy=1",
                     Dout, EN, Phase, Ready);
        end
        n_tests++;
        if (DbgState !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, exp %0d", DbgState, ST_IDLE);
        end
        nReset = 1'b1;
        repeat (3) begin
            cycle();
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL reset_model t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
        end
    endtask

    task automatic test_square();
        logic [DW-1:0] dv[$];
        bit            ev[$];
        int            i0;
        logic [DW-1:0] exp_d;
        bit            exp_e;
        Run = 1'b0;
        load_cfg(12'hC00, 12'h100, 3, 5, 12'h000);
        repeat (3) begin
            cycle();
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL square_idle t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
        end
        Run = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cycle();
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL square_model t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
            dv.push_back(Dout);
            ev.push_back(EN);
        end
        i0 = -1;
        for (int k = 0; k < 30; k++) if (i0 < 0 && dv[k] == 12'hC00) i0 = k;
        n_tests++;
        if (i0 != 1) begin
            n_fail++;
            $display("FAIL square_start: first 0xC00 at cycle %0d, exp 1", i0);
        end else begin
            for (int k = 0; k < 20; k++) begin
                exp_d = ((k % 8) < 3) ? 12'hC00 : 12'h100;
                n_tests++;
                if (dv[i0 + k] !== exp_d) begin
                    n_fail++;
                    $display("FAIL square_level k=%0d: got %h, exp %h", k, dv[i0 + k], exp_d);
                end
            end
            for (int k = 2; k < 22; k++) begin
                exp_e = (((k - 2) % 8) == 0) || (((k - 2) % 8) == 3);
                n_tests++;
                if (ev[i0 + k] !== exp_e) begin
                    n_fail++;
                    $display("FAIL square_en k=%0d: got %b, exp %b", k, ev[i0 + k], exp_e);
                end
            end
        end
    endtask

    task automatic test_toggle();
        logic [DW-1:0] dv[$];
        bit            ev[$];
        load_cfg(12'h3A5, 12'h05A, 0, 0, 12'h000);
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL toggle_model t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
            dv.push_back(Dout);
            ev.push_back(EN);
        end
        for (int k = 12; k < 20; k++) begin
            n_tests++;
            if (dv[k] === dv[k - 1] || ev[k] !== 1'b1 ||
                (dv[k] !== 12'h3A5 && dv[k] !== 12'h05A)) begin
                n_fail++;
                $display("FAIL toggle_every_cycle k=%0d: got dout=%h prev=%h en=%b, exp alternating 3a5/05a with en=1",
                         k, dv[k], dv[k - 1], ev[k]);
            end
        end
    endtask

    task automatic test_load_midhigh();
        bit found;
        bit seen800;
        load_cfg(12'hC00, 12'h100, 3, 5, 12'h000);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle();
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL load_wait_model t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
            if (m_mode == M_HIGH && m_left == 2 && !m_pend && m_ahi == 'hC00) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL load_wait: mid-HIGH point not reached within 40 cycles, got none, exp one");
            return;
        end
        load_cfg(12'h800, 12'h100, 3, 5, 12'h000);
        n_tests++;
        if (Ready !== 1'b0 || Dout !== 12'hC00) begin
            n_fail++;
            $display("FAIL load_accept: got rdy=%b dout=%h, exp rdy=0 dout=c00", Ready, Dout);
        end
        load_cfg(12'h555, 12'h100, 3, 5, 12'h000);
        n_tests++;
        if (Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_ignored_rdy: got rdy=%b, exp 0", Ready);
        end
        seen800 = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL load_model t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
            if (!seen800 && Dout === 12'h800) begin
                seen800 = 1;
                n_tests++;
                if (Ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_commit_rdy: got rdy=%b when 0x800 shown, exp 1", Ready);
                end
            end
            n_tests++;
            if (Dout === 12'h555) begin
                n_fail++;
                $display("FAIL load_second_ignored: got dout=555, exp never 555");
            end
        end
        n_tests++;
        if (!seen800) begin
            n_fail++;
            $display("FAIL load_commit: got no 0x800 within 20 cycles, exp 0x800 at next HIGH");
        end
    endtask

    task automatic test_run_drop();
        bit found;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle();
            if (m_mode == M_HIGH && m_left == 2) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL drop_wait: got no HIGH phase within 40 cycles, exp one");
            return;
        end
        Run = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL drop_model t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
            if (k == 1) begin
                n_tests++;
                if (DbgState !== ST_IDLE) begin
                    n_fail++;
                    $display("FAIL drop_idle: got state %0d, exp %0d", DbgState, ST_IDLE);
                end
            end
            if (k == 2) begin
                n_tests++;
                if (Dout !== 12'h100) begin
                    n_fail++;
                    $display("FAIL drop_level: got %h, exp 100", Dout);
                end
            end
            if (k == 4 || k == 5) begin
                n_tests++;
                if (EN !== (k == 4)) begin
                    n_fail++;
                    $display("FAIL drop_en k=%0d: got %b, exp %b", k, EN, (k == 4));
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        bit found;
        Run = 1'b1;
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            cycle();
            if (upd_hist.size() > 0 && upd_hist[upd_hist.size() - 1]) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_wait: got no level change within 30 cycles, exp one");
            return;
        end
        #2 nReset = 1'b0;
        #1;
        n_tests++;
        if ({Dout, EN, Phase, Ready} !== {12'h000, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_async: got dout=%h en=%b ph=%b rdy=%b, exp dout=000 en=0 ph=0 rdy=1",
                     Dout, EN, Phase, Ready);
        end
        model_reset();
        Run = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_tests++;
            if (EN !== 1'b0 || Dout !== 12'h000 || Ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_flush k=%0d: got en=%b dout=%h rdy=%b, exp en=0 dout=000 rdy=1",
                         k, EN, Dout, Ready);
            end
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL rst_model t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
        end
    endtask

    task automatic test_slew();
        logic [DW-1:0] dv[$];
        bit            ev[$];
        Run = 1'b0;
        load_cfg(12'h00A, 12'h000, 8, 8, 12'h004);
        repeat (2) cycle();
        Run = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL slew_model t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
            dv.push_back(Dout);
            ev.push_back(EN);
        end
`ifdef SQVL_SLEW_EN
        n_tests++;
        if (dv[1] !== 12'h004 || dv[2] !== 12'h008 || dv[3] !== 12'h00A || dv[4] !== 12'h00A) begin
            n_fail++;
            $display("FAIL slew_ramp: got %h %h %h %h, exp 004 008 00a 00a", dv[1], dv[2], dv[3], dv[4]);
        end
        n_tests++;
        if ({ev[3], ev[4], ev[5], ev[6]} !== 4'b1110) begin
            n_fail++;
            $display("FAIL slew_en: got %b%b%b%b, exp 1110", ev[3], ev[4], ev[5], ev[6]);
        end
`else
        n_tests++;
        if (dv[1] !== 12'h00A || dv[2] !== 12'h00A) begin
            n_fail++;
            $display("FAIL jump_level: got %h %h, exp 00a 00a", dv[1], dv[2]);
        end
        n_tests++;
        if ({ev[3], ev[4]} !== 2'b10) begin
            n_fail++;
            $display("FAIL jump_en: got %b%b, exp 10", ev[3], ev[4]);
        end
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            Run = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0) begin
                HiLevel  = DW'($urandom_range(0, 4095));
                LoLevel  = DW'($urandom_range(0, 4095));
                HiCycles = CW'($urandom_range(0, 4));
                LoCycles = CW'($urandom_range(0, 4));
                SlewStep = DW'($urandom_range(0, 3) * 300);
                Load     = 1'b1;
            end else begin
                Load = 1'b0;
            end
            cycle();
            n_tests++;
            if ({Dout, EN, Phase, Ready} !== {DW'(m_dout), m_en, m_phase, ~m_pend}) begin
                n_fail++;
                $display("FAIL random_model t=%0t: got dout=%h en=%b ph=%b rdy=%b, exp dout=%h en=%b ph=%b rdy=%b",
                         $time, Dout, EN, Phase, Ready, DW'(m_dout), m_en, m_phase, ~m_pend);
            end
        end
        Load = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_square();
        test_toggle();
        test_load_midhigh();
        test_run_drop();
        test_reset_inflight();
        test_slew();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sqvl_level_gen.md
# sqvl_level_gen

Square-wave level source for the SQVL voltage path. It generates the 12-bit high and low voltage codes and the matching latch-enable strobe that the SQVL voltage path consumes. The output drives the voltage path's data input and enable directly. The strobe is delayed internally so that it lines up with the path's two-stage register pipeline in front of its enabled latch. Period, duty and levels are loaded through a shadow-register handshake and committed only at period boundaries, so a new setting never produces a glitched level.

## Interface
- DW, 12, level code width
- CW, 16, phase-length counter width
- EN_DLY, 2, cycles from a Dout update to its EN strobe; equals the downstream pipeline depth
- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- Run  in  1  level 1 = generate square wave, 0 = park at low level
- Load  in  1  one-cycle request to capture HiLevel/LoLevel/HiCycles/LoCycles/SlewStep into shadow
- Ready  out  1  1 = Load is accepted this cycle
- HiLevel, LoLevel  in  DW  level codes
- HiCycles, LoCycles  in  CW  phase lengths in clocks; 0 is treated as 1
- SlewStep  in  DW  per-cycle step size; used only with SQVL_SLEW_EN
- Dout  out  DW  level code to the voltage path
- EN  out  1  latch strobe to the voltage path
- Phase  out  1  1 = high phase active

## Operation
- Reset state for all outputs and registers:
  - FSM in IDLE; active and shadow registers 0; pending flag 0.
  - Dout=0, EN=0, Phase=0, Ready=1.
- FSM states are IDLE, HIGH and LOW.
  - IDLE→HIGH when Run=1.
  - HIGH→LOW after max(HiCycles,1) cycles in HIGH.
  - LOW→HIGH after max(LoCycles,1) cycles in LOW.
  - Any state→IDLE on the edge after Run=0.
  - In IDLE, Dout targets the active LoLevel.
- Phase length counter:
  - Resets to 1 on each phase entry and compares against the active length.
  - Width CW; it never wraps, because the compare terminates the phase first.
- Load handshake:
  - Load with Ready=1 copies the inputs into shadow, sets pending, and drops Ready.
  - Load with Ready=0 is ignored.
- Commit from shadow to active:
  - In IDLE, on the next edge.
  - Otherwise, on the edge that enters HIGH (period start).
  - Commit clears pending and raises Ready.
- Simultaneous Load and period start: the shadow captures the new values, but the commit occurs at the following period start, not the current one.
- Level update:
  - Each cycle, Dout moves toward the current target (HiLevel in HIGH, LoLevel in LOW/IDLE).
  - Every cycle in which Dout changes value is an update cycle.
- EN is the update marker delayed by exactly EN_DLY cycles, giving a one-cycle pulse per update cycle. Consecutive updates produce consecutive EN pulses.
- Run dropped mid-phase: the counter is abandoned, Dout goes to LoLevel, and an EN follows if the value changed.
- nReset asserted mid-operation clears everything asynchronously, including EN pulses in flight in the delay line.

## Timing
- Edge 0 samples Run=1 in IDLE. After edge 1, Dout=HiLevel and Phase=1. After edge 1+EN_DLY, EN=1 for one cycle.
- HIGH lasts HiCycles clocks; LOW lasts LoCycles clocks. The period is HiCycles+LoCycles with no idle cycles between phases.
- Ready is low from the edge after an accepted Load until the commit edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SQVL_SLEW_EN defined:
  - Dout steps toward the target by SlewStep per cycle, saturating at the target. It never overshoots, and the arithmetic is unsigned DW-bit with clamp.
  - SlewStep=0 means a direct jump.
  - The phase counter runs independently of slew progress.
  - Each step is an update cycle and produces an EN.
- SQVL_SLEW_EN undefined:
  - Dout jumps to the target in one cycle.
  - SlewStep is ignored.
  - Exactly one EN per level change.

## Structure
- Package sqvl_pkg holds:
  - the state enum (IDLE/HIGH/LOW);
  - DW, CW and EN_DLY defaults;
  - the config record type grouping the levels, lengths and step.
- Sub-module sqvl_en_delay: an EN_DLY-stage shift register with asynchronous active-low clear, taking the update marker in and producing EN out.

## Test plan
- Reset, then HiLevel=0xC00, LoLevel=0x100, HiCycles=3, LoCycles=5, Run=1 → Dout alternates 0xC00 for 3 cycles and 0x100 for 5. Each change is followed by one EN pulse exactly 2 cycles later.
- HiCycles=0, LoCycles=0 → Dout toggles every cycle, and EN pulses every cycle after 2-cycle latency.
- Load new HiLevel=0x800 mid-HIGH → Ready=0 and the level is unchanged until the next HIGH entry, which shows 0x800, then Ready=1. A second Load while Ready=0 has no effect.
- Run dropped in HIGH → Dout=LoLevel on the next edge, FSM goes to IDLE, and one EN follows 2 cycles later.
- nReset pulsed while an EN is in flight → Dout=0, EN never asserts, and Ready=1.
- With SQVL_SLEW_EN, Lo=0x000, Hi=0x00A, Step=4 → Dout reads 0x004, 0x008, 0x00A on three EN-strobed cycles, then holds.
